// File: rtl/extract_round_ctrl.sv
// ============================================================================
// extract_round_ctrl
// ----------------------------------------------------------------------------
// Sequencing controller for the float-to-key extractor. The controller pulls
// triples of single-precision chaotic-map words from the upstream generator
// and issues each triple to the extractor as a one-cycle enable. It keeps at
// most one extractor transaction in flight, forwards the three 23-bit keys
// downstream, counts rounds up to a programmed total, and raises a sticky
// flag when the extractor fails to answer in time.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   start, num_rounds         run request and round total (sampled on start)
//   busy, done, error_timeout run status, completion pulse, sticky timeout
//   in_valid/in_ready, in_v*  upstream triple handshake and float words
//   ext_enable, ext_val*      extractor issue pulse and held operands
//   ext_valid, ext_ex*        extractor result strobe and key values
//   out_valid/out_ready,      downstream handshake with registered keys,
//   out_ex*, out_index,       0-based round number and final-round marker
//   out_last
// ============================================================================
module extract_round_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_rounds,
    output logic             busy,
    output logic             done,
    output logic             error_timeout,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_v1,
    input  logic [31:0]      in_v2,
    input  logic [31:0]      in_v3,
    output logic             ext_enable,
    output logic [31:0]      ext_val1,
    output logic [31:0]      ext_val2,
    output logic [31:0]      ext_val3,
    input  logic             ext_valid,
    input  logic [22:0]      ext_ex1,
    input  logic [22:0]      ext_ex2,
    input  logic [22:0]      ext_ex3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [22:0]      out_ex1,
    output logic [22:0]      out_ex2,
    output logic [22:0]      out_ex3,
    output logic [CNT_W-1:0] out_index,
    output logic             out_last
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   num_q;
    logic [CNT_W-1:0]   round_cnt;
    logic [TIMER_W-1:0] timer;

    // The only output that must react within the FETCH cycle itself.
    assign in_ready = (state == S_FETCH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            num_q         <= '0;
            round_cnt     <= '0;
            timer         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error_timeout <= 1'b0;
            ext_enable    <= 1'b0;
            ext_val1      <= '0;
            ext_val2      <= '0;
            ext_val3      <= '0;
            out_valid     <= 1'b0;
            out_ex1       <= '0;
            out_ex2       <= '0;
            out_ex3       <= '0;
            out_index     <= '0;
            out_last      <= 1'b0;
        end else begin
            // Pulse outputs default low; each is raised on entry to its state.
            ext_enable <= 1'b0;
            done       <= 1'b0;

            case (state)
                S_IDLE, S_ERR: begin
                    if (start) begin
                        error_timeout <= 1'b0;
                        busy          <= 1'b1;
                        if (num_rounds != '0) begin
                            num_q     <= num_rounds;
                            round_cnt <= '0;
                            state     <= S_FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end

                S_FETCH: begin
                    if (in_valid) begin
                        ext_val1   <= in_v1;
                        ext_val2   <= in_v2;
                        ext_val3   <= in_v3;
                        ext_enable <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    // A result arriving on the last permitted cycle still wins.
                    if (ext_valid) begin
                        out_ex1   <= ext_ex1;
                        out_ex2   <= ext_ex2;
                        out_ex3   <= ext_ex3;
                        out_index <= round_cnt;
                        out_last  <= (round_cnt == num_q - 1'b1);
                        out_valid <= 1'b1;
                        state     <= S_EMIT;
                    end else begin
                        timer <= timer + 1'b1;
                        if (timer == TIMER_W'(TIMEOUT - 1)) begin
                            error_timeout <= 1'b1;
                            busy          <= 1'b0;
                            state         <= S_ERR;
                        end
                    end
                end

                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            round_cnt <= round_cnt + 1'b1;
                            state     <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
